// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, request record and arbiter state shared by the ALU and its arbiter
package alu_pkg;
  localparam int ALU_XLEN = 32;
  localparam int ALU_OPW = 6;
  localparam logic [5:0] OP_ADD = 6'h01, OP_SLL = 6'h02, OP_SLT = 6'h03, OP_SLTU = 6'h04;
  localparam logic [5:0] OP_XOR = 6'h05, OP_SRL = 6'h06, OP_SRA = 6'h07, OP_OR = 6'h08;
  localparam logic [5:0] OP_AND = 6'h09, OP_SUB = 6'h0A, OP_BEQ = 6'h0B, OP_BNE = 6'h0C;
  localparam logic [5:0] OP_BLT = 6'h0D, OP_BGE = 6'h0E, OP_BLTU = 6'h0F, OP_BGEU = 6'h10;
  localparam logic [5:0] OP_JAL = 6'h11, OP_MAX = 6'h11;
  typedef struct packed {
    logic [ALU_OPW-1:0] op;
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
  } alu_req_t;
  typedef enum logic {IDLE, RESP} arb_state_e;
endpackage

// File: rtl/alu.sv
// alu: existing single-cycle ALU, purely combinational
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int OPW = ALU_OPW
) (
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  logic flag;
  // branch compares collapse to a single flag bit
  always_comb begin
    flag = 1'b0;
    case (op)
      OP_BEQ:  flag = a == b;
      OP_BNE:  flag = a != b;
      OP_BLT:  flag = $signed(a) < $signed(b);
      OP_BGE:  flag = $signed(a) >= $signed(b);
      OP_BLTU: flag = a < b;
      OP_BGEU: flag = a >= b;
      default: flag = 1'b0;
    endcase
  end
  // opcode decode; unknown opcodes yield zero
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:                               y = a + b;
      OP_SLL:                               y = a << b[4:0];
      OP_SLT, OP_SLTU:                      y = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:                               y = a ^ b;
      OP_SRL, OP_SRA:                       y = a >> b[4:0];
      OP_OR:                                y = a | b;
      OP_AND:                               y = a & b;
      OP_SUB:                               y = a - b;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
      OP_BLTU, OP_BGEU:                     y = {{(XLEN-1){1'b0}}, flag};
      OP_JAL:                               y = a;
      default:                              y = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  // scan from the farthest offset down so the nearest hit wins
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        idx = W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU with a held, one-cycle-latency response
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN = ALU_XLEN,
  parameter int OPW = ALU_OPW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0][OPW-1:0]   req_op_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [XLEN-1:0]               rsp_result_o,
  output logic                          rsp_illegal_o,
  output logic                          busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e state_q, state_d;
  alu_req_t req_q, req_d;
  logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic pick_valid, can_accept, grant;
  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req(req_valid_i),
    .ptr(rr_ptr_q),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  alu #(.XLEN(XLEN), .OPW(OPW)) u_alu (
    .op(req_q.op),
    .a(req_q.a),
    .b(req_q.b),
    .y(rsp_result_o)
  );
  assign busy_o = state_q == RESP;
  assign rsp_valid_o = busy_o ? NUM_REQ'(1) << owner_q : '0;
  assign rsp_illegal_o = busy_o && (req_q.op == '0 || req_q.op > OP_MAX);
  // a slot frees when idle or when the owner takes its response this cycle
  always_comb begin
    can_accept = !busy_o || rsp_ready_i[owner_q];
    grant = can_accept && pick_valid;
    req_ready_o = grant ? NUM_REQ'(1) << pick_idx : '0;
    state_d = (grant || !can_accept) ? RESP : IDLE;
    req_d = grant ? '{op: req_op_i[pick_idx], a: req_a_i[pick_idx], b: req_b_i[pick_idx]} : req_q;
    owner_d = grant ? pick_idx : owner_q;
    rr_ptr_d = !grant ? rr_ptr_q : pick_idx == IW'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
  end
  // state, held request, owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q <= '0;
      owner_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      owner_q <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a response scoreboard
module tb_alu_share_arbiter;
  localparam int N = 2, XLEN = 32, OPW = 6;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid_i = '0, rsp_ready_i = '0, req_ready_o, rsp_valid_o;
  logic [N-1:0][OPW-1:0] req_op_i = '0;
  logic [N-1:0][XLEN-1:0] req_a_i = '0, req_b_i = '0;
  logic [XLEN-1:0] rsp_result_o;
  logic rsp_illegal_o, busy_o;
  typedef struct packed {
    logic [N-1:0] own;
    logic [XLEN-1:0] res;
    logic ill;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_illegal_o(rsp_illegal_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int o, logic [XLEN-1:0] r, logic il);
    q.push_back(exp_t'{own: N'(1 << o), res: r, ill: il});
  endtask

  task automatic set_req(int i, logic v, logic [OPW-1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    req_valid_i[i] = v;
    req_op_i[i] = op;
    req_a_i[i] = a;
    req_b_i[i] = b;
  endtask

  // scoreboard monitor: every response handshake consumes one expected entry
  always @(negedge clk) begin
    if (!reset && |(rsp_valid_o & rsp_ready_i)) begin
      if (q.size() == 0) chk("rsp_unexpected", XLEN'(rsp_valid_o), '0);
      else begin
        e = q.pop_front();
        chk("rsp_owner", XLEN'(rsp_valid_o), XLEN'(e.own));
        chk("rsp_result", rsp_result_o, e.res);
        chk("rsp_illegal", XLEN'(rsp_illegal_o), XLEN'(e.ill));
      end
    end
  end

  initial begin
    // 1: reset, then a single add
    step(); step();
    reset = 1'b0;
    #2;
    chk("rst_req_ready", XLEN'(req_ready_o), 0);
    chk("rst_rsp_valid", XLEN'(rsp_valid_o), 0);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_illegal", XLEN'(rsp_illegal_o), 0);
    chk("rst_busy", XLEN'(busy_o), 0);
    set_req(0, 1, 6'h01, 5, 7);
    rsp_ready_i = 2'b11;
    #1 chk("t1_ready", XLEN'(req_ready_o), 1);
    push(0, 12, 0);
    step();
    req_valid_i = '0;
    #2 chk("t1_rsp_valid", XLEN'(rsp_valid_o), 1);
    chk("t1_busy", XLEN'(busy_o), 1);
    step(); step();
    // 2: alternating back-to-back grants from rr_ptr=0
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    set_req(0, 1, 6'h0A, 10, 3);
    set_req(1, 1, 6'h05, 32'hF0, 32'hFF);
    for (int k = 0; k < 6; k++) begin
      #2 chk("t2_ready", XLEN'(req_ready_o), (k % 2) != 0 ? 2 : 1);
      push(k % 2, (k % 2) != 0 ? 32'h0F : 32'd7, 0);
      step();
    end
    req_valid_i = '0;
    step(); step();
    // 3: backpressure on req1, non-owner ready ignored, release with same-cycle grant
    set_req(1, 1, 6'h0D, 32'hFFFF_FFFF, 1);
    rsp_ready_i = 2'b00;
    #2 chk("t3_ready", XLEN'(req_ready_o), 2);
    push(1, 1, 0);
    step();
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 6'h09, 32'hFF00, 32'h0FF0);
    rsp_ready_i = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #2 chk("t3_hold_valid", XLEN'(rsp_valid_o), 2);
      chk("t3_hold_result", rsp_result_o, 1);
      chk("t3_hold_ready", XLEN'(req_ready_o), 0);
      step();
    end
    rsp_ready_i = 2'b10;
    #2 chk("t3_regrant", XLEN'(req_ready_o), 1);
    push(0, 32'h0F00, 0);
    step();
    req_valid_i = '0;
    rsp_ready_i = 2'b11;
    #2 chk("t3_next_valid", XLEN'(rsp_valid_o), 1);
    step(); step();
    // 4: illegal opcode then pass-A
    set_req(0, 1, 6'h20, 32'h55, 32'h66);
    #2 chk("t4_ready", XLEN'(req_ready_o), 1);
    push(0, 0, 1);
    step();
    set_req(0, 1, 6'h11, 32'h104, 0);
    #2 chk("t4_illegal", XLEN'(rsp_illegal_o), 1);
    chk("t4_ready2", XLEN'(req_ready_o), 1);
    push(0, 32'h104, 0);
    step();
    req_valid_i = '0;
    #2 chk("t4_legal", XLEN'(rsp_illegal_o), 0);
    chk("t4_result", rsp_result_o, 32'h104);
    step(); step();
    // 5: reset while a response is held drops it
    set_req(0, 1, 6'h01, 1, 1);
    rsp_ready_i = 2'b00;
    #2 chk("t5_ready", XLEN'(req_ready_o), 1);
    step();
    req_valid_i = '0;
    #2 chk("t5_busy", XLEN'(busy_o), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2 chk("t5_rsp_valid", XLEN'(rsp_valid_o), 0);
    chk("t5_busy_clr", XLEN'(busy_o), 0);
    set_req(1, 1, 6'h08, 32'hF0, 32'h0F);
    rsp_ready_i = 2'b11;
    #1 chk("t5_req1_ready", XLEN'(req_ready_o), 2);
    push(1, 32'hFF, 0);
    step();
    req_valid_i = '0;
    step(); step();
    // 6: req1 alone every cycle, then req0 wins the next contested pick
    for (int k = 0; k < 5; k++) begin
      set_req(1, 1, 6'h01, k, 100);
      #2 chk("t6_req1_ready", XLEN'(req_ready_o), 2);
      push(1, 100 + k, 0);
      step();
    end
    set_req(0, 1, 6'h02, 1, 4);
    set_req(1, 1, 6'h01, 5, 100);
    #2 chk("t6_req0_first", XLEN'(req_ready_o), 1);
    push(0, 16, 0);
    step();
    #2 chk("t6_req1_next", XLEN'(req_ready_o), 2);
    push(1, 105, 0);
    step();
    req_valid_i = '0;
    step(); step(); step();
    chk("sb_empty", XLEN'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single-cycle ALU between NUM_REQ requesters, e.g. req 0 = execute stage and req 1 = branch/address unit, using round-robin arbitration with valid/ready handshakes. It registers the granted op/operands and drives one internal ALU instance from that register. The response is presented back to the granted requester and held until that requester accepts it.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
XLEN, 32, operand/result width
OPW, 6, ALU opcode width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accepted this cycle (one-hot or zero)
req_op_i  in  NUM_REQ x OPW  per-requester ALU opcode
req_a_i  in  NUM_REQ x XLEN  per-requester operand A
req_b_i  in  NUM_REQ x XLEN  per-requester operand B
rsp_valid_o  out  NUM_REQ  response valid, one-hot to the owning requester
rsp_ready_i  in  NUM_REQ  per-requester response accept
rsp_result_o  out  XLEN  shared result bus, meaningful only where rsp_valid_o is set
rsp_illegal_o  out  1  opcode of the held response is outside 0x01..0x11
busy_o  out  1  a response is held (state RESP)

Behaviour:
- Reset (synchronous, active-high) sets:
  - state = IDLE, rr_ptr = 0
  - op/operand/owner registers = 0
  - all outputs = 0
- Reset mid-transaction drops the pending response without delivering it.
- States:
  - IDLE: no response held.
  - RESP: a registered op is held; its result is on rsp_result_o.
- can_accept = (state==IDLE) OR (state==RESP AND rsp_ready_i[owner]).
- Grant:
  - When can_accept, choose the first valid requester searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready_o[g]=1 for that requester only. req_ready_o depends combinationally on req_valid_i and rsp_ready_i.
- On handshake (req_valid_i[g] AND req_ready_o[g]) at edge N:
  - op/a/b of g are registered, owner = g, rr_ptr = (g+1) mod NUM_REQ, state = RESP.
- Latency: rsp_valid_o[owner]=1 in cycle N+1. The request-to-response latency is exactly 1 cycle.
- rsp_result_o is the combinational output of the internal ALU, driven from the registered op/a/b.
- Response hold: rsp_valid_o, rsp_result_o and rsp_illegal_o stay stable until rsp_ready_i[owner]=1.
  - rsp_ready_i of non-owners is ignored.
- Release with no new grant in the same cycle: state = IDLE at the next edge.
- Release plus a new grant in the same cycle: state stays RESP with the new owner, giving back-to-back, 1 op/cycle throughput.
- rr_ptr advances only on a grant. An idle cycle does not move it.
- ALU semantics, unchanged from the existing ALU:
  - 0x01 add, 0x02 sll, 0x03/0x04 unsigned lt, 0x05 xor
  - 0x06/0x07 logical right shift by b[4:0], 0x08 or, 0x09 and, 0x0A sub
  - 0x0B..0x10 branch compares giving {31'b0,flag}, 0x11 pass A
  - any other opcode gives 0
- rsp_illegal_o = registered op not in 0x01..0x11. It is valid only while rsp_valid_o is set, else 0.
- The arbiter does not check or modify operand widths or values. Wrap-around arithmetic is the ALU's.
- A requester dropping req_valid_i before the handshake is legal; no state changes.
- No starvation: with all requesters continuously valid and ready, each is granted once every NUM_REQ grants.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU opcode localparams (OP_ADD=6'h01 … OP_JAL=6'h11, OP_MAX=6'h11)
  - typedef alu_req_t {op, a, b}
  - typedef enum {IDLE, RESP} arb_state_e
- One sub-module: rr_pick, the combinational round-robin pick over NUM_REQ with rr_ptr.
- The existing ALU is instantiated once, unmodified.

Test Plan:
1. Reset held 2 cycles, then released: all outputs 0, busy_o=0. Then req0 op=0x01, a=5, b=7 → req_ready_o=01; next cycle rsp_valid_o=01, rsp_result_o=12.
2. req0 and req1 valid from rr_ptr=0, rsp_ready always 1. req0 op=0x0A a=10 b=3; req1 op=0x05 a=0xF0 b=0xFF → grants alternate 0,1,0,1…; results 7 and 0x0F, one per cycle, no bubble.
3. Backpressure: req1 op=0x0D a=0xFFFFFFFF b=1, rsp_ready_i=0 for 3 cycles → rsp_valid_o=10 and rsp_result_o=1 stable; req_ready_o=00 throughout; accepted on cycle 4, with same-cycle grant of pending req0.
4. Illegal op: req0 op=0x20 → rsp_result_o=0, rsp_illegal_o=1. Next op 0x11 a=0x104 → result 0x104, rsp_illegal_o=0.
5. Reset asserted while in RESP with rsp_ready_i=0 → next cycle rsp_valid_o=0, busy_o=0, rr_ptr=0. The following req1-only request is granted normally.
6. Only req1 valid for 5 cycles → granted every cycle. rr_ptr stays at 0, so an arriving req0 is granted first on the following arbitration.
